rr_arb_4: RTL and testbench

RR_ARB_4 -- requirements
Module: rr_arb_4

---
 rtl/rr_arb_4.sv | 109 ++++++++++
 tb/tb_rr_arb_4.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_4.sv
// rtl/rr_arb_4.sv - four-way round-robin arbiter with registered grant and hold-limit revoke
module rr_arb_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  hold_q, hold_d;
    logic        timeout_q, timeout_d;

    logic        pick_found;
    logic [1:0]  pick_idx;
    logic        hold_limit;
    logic        req_sel;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        logic [1:0] cand;
        pick_found = 1'b0;
        pick_idx   = last_q;
        cand       = last_q;
        for (int i = 0; i < 4; i++) begin
            cand = last_q + 2'(i + 1);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign hold_limit = (hold_q == 8'(MAX_HOLD));
    assign req_sel    = req[sel_q];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        last_d    = last_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << pick_idx;
                    sel_d   = pick_idx;
                    hold_d  = 8'd1;
                end
            end
            GRANT: begin
                if (done || !req_sel || hold_limit) begin
                    state_d   = IDLE;
                    gnt_d     = 4'b0000;
                    last_d    = sel_q;
                    hold_d    = 8'd0;
                    // A done or dropped request wins over the hold limit.
                    timeout_d = hold_limit && !done && req_sel;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                hold_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'd0;
            last_q    <= 2'd3;
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arb_4.sv
// tb/tb_rr_arb_4.sv - scoreboard bench for rr_arb_4 with hold limits 8 and 1
module tb_rr_arb_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;

    logic [3:0] gnt8, gnt1;
    logic [1:0] sel8, sel1;
    logic       gv8, gv1;
    logic       to8, to1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       st;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [1:0] last;
        int         hold;
        logic       to;
    } model_t;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       gv;
        logic       to;
    } exp_t;

    localparam model_t MODEL_RST = '{st: 1'b0, gnt: 4'b0, sel: 2'd0, last: 2'd3, hold: 0, to: 1'b0};

    model_t m8 = MODEL_RST;
    model_t m1 = MODEL_RST;
    exp_t   q8[$];
    exp_t   q1[$];

    rr_arb_4 #(.MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt8), .sel(sel8), .gnt_valid(gv8), .timeout(to8)
    );

    rr_arb_4 #(.MAX_HOLD(1)) dut_h1 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt1), .sel(sel1), .gnt_valid(gv1), .timeout(to1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic model_t step(input model_t m, input logic [3:0] r, input logic d, input int mh);
        model_t n;
        bit     found;
        int     k;
        n     = m;
        n.to  = 1'b0;
        found = 1'b0;
        if (!m.st) begin
            for (int i = 1; i <= 4; i++) begin
                k = (int'(m.last) + i) % 4;
                if (!found && r[k]) begin
                    found  = 1'b1;
                    n.st   = 1'b1;
                    n.gnt  = 4'b0001 << k;
                    n.sel  = 2'(k);
                    n.hold = 1;
                end
            end
        end else if (d || !r[m.sel] || m.hold == mh) begin
            n.st   = 1'b0;
            n.gnt  = 4'b0;
            n.last = m.sel;
            n.hold = 0;
            n.to   = !d && r[m.sel] && (m.hold == mh);
        end else begin
            n.hold = m.hold + 1;
        end
        return n;
    endfunction

    always @(negedge rst_n) begin
        m8 = MODEL_RST;
        m1 = MODEL_RST;
        q8.delete();
        q1.delete();
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            m8 = step(m8, req, done, 8);
            m1 = step(m1, req, done, 1);
            q8.push_back('{gnt: m8.gnt, sel: m8.sel, gv: |m8.gnt, to: m8.to});
            q1.push_back('{gnt: m1.gnt, sel: m1.sel, gv: |m1.gnt, to: m1.to});
        end
    end

    // Scoreboard pop plus the zero-or-one-hot invariant on every falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q8.size() != 0) begin
            e = q8.pop_front();
            chk("sb8_gnt", gnt8, e.gnt);
            chk("sb8_sel", sel8, e.sel);
            chk("sb8_valid", gv8, e.gv);
            chk("sb8_timeout", to8, e.to);
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("sb1_gnt", gnt1, e.gnt);
            chk("sb1_sel", sel1, e.sel);
            chk("sb1_valid", gv1, e.gv);
            chk("sb1_timeout", to1, e.to);
        end
        chk("inv8_onehot0", $onehot0(gnt8), 1);
        chk("inv8_valid", gv8, |gnt8);
        if (gv8) chk("inv8_sel", gnt8, 4'b0001 << sel8);
        chk("inv1_onehot0", $onehot0(gnt1), 1);
        if (gv1) chk("inv1_sel", gnt1, 4'b0001 << sel1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = 4'b0;
        done  = 1'b0;
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 4'b0;
        done  = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_gnt", gnt8, 4'b0);
        chk("rst_sel", sel8, 2'd0);
        chk("rst_valid", gv8, 1'b0);
        chk("rst_timeout", to8, 1'b0);
        cyc(2);
        rst_n = 1'b1;

        // First grant after reset favours requester 0 side of the search.
        req = 4'b1010;
        cyc(1);
        chk("first_gnt", gnt8, 4'b0010);
        chk("first_sel", sel8, 2'd1);
        chk("first_valid", gv8, 1'b1);
        req = 4'b0000;
        cyc(1);
        chk("drop_gnt", gnt8, 4'b0);
        chk("idle_sel_hold", sel8, 2'd1);
        done = 1'b1;
        cyc(2);
        chk("idle_done_ignored", gnt8, 4'b0);
        done = 1'b0;

        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            cyc(1);
            chk("rot_gnt", gnt8, 4'b0001 << (g % 4));
            done = 1'b1;
            cyc(1);
            chk("rot_gap", gnt8, 4'b0);
            done = 1'b0;
        end

        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            chk("hold_gnt", gnt8, 4'b0100);
            chk("hold_no_to", to8, 1'b0);
        end
        cyc(1);
        chk("limit_gnt", gnt8, 4'b0);
        chk("limit_timeout", to8, 1'b1);
        cyc(1);
        chk("regrant_gnt", gnt8, 4'b0100);
        chk("regrant_to", to8, 1'b0);

        do_reset();
        req = 4'b1000;
        cyc(2);
        chk("r3_gnt", gnt8, 4'b1000);
        req = 4'b0011;
        cyc(1);
        chk("r3_drop_gnt", gnt8, 4'b0);
        chk("r3_drop_to", to8, 1'b0);
        cyc(1);
        chk("r3_wrap_gnt", gnt8, 4'b0001);

        do_reset();
        req = 4'b0100;
        cyc(8);
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        chk("coin_gnt", gnt8, 4'b0);
        chk("coin_to", to8, 1'b0);

        do_reset();
        req = 4'b1000;
        cyc(2);
        chk("arst_pre", gnt8, 4'b1000);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", gnt8, 4'b0);
        chk("arst_sel", sel8, 2'd0);
        chk("arst_valid", gv8, 1'b0);
        chk("arst_to", to8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        chk("arst_regrant", gnt8, 4'b1000);

        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("h1_gnt", gnt1, 4'b0001 << i);
            cyc(1);
            chk("h1_gap", gnt1, 4'b0);
            chk("h1_to", to1, 1'b1);
        end

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 5) == 0);
        end
        req  = 4'b0;
        done = 1'b0;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
